// File: rtl/io_uart_tx_if.sv
// rtl/io_uart_tx_if.sv - FemtoRV32 IO-region bus bundle for the UART transmitter
interface io_uart_tx_if;
    logic        io_sel;
    logic [1:0]  reg_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;

    modport master (
        output io_sel, reg_addr, mem_wdata, mem_wmask, mem_rstrb,
        input  mem_rdata, mem_rbusy, mem_wbusy
    );

    modport slave (
        input  io_sel, reg_addr, mem_wdata, mem_wmask, mem_rstrb,
        output mem_rdata, mem_rbusy, mem_wbusy
    );
endinterface

// File: rtl/io_uart_tx.sv
// rtl/io_uart_tx.sv - memory-mapped 8N1 UART transmitter with byte FIFO and overflow hold register
module io_uart_tx #(
    parameter int CLK_HZ     = 48000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    io_uart_tx_if.slave  bus,
    output logic         tx,
    output logic         irq
);
    localparam int DIV  = CLK_HZ / BAUD;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(DIV);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic            hold_valid;
    logic [7:0]      hold_data;
    logic            overflow;
    logic            irq_en;
    logic [31:0]     rdata_q;
    logic            irq_q;

    logic [1:0]      state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            tx_q;

    logic            wr_en;
    logic            data_wr;
    logic            ctrl_wr;
    logic            rd_en;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push_wr;
    logic            hold_xfer;
    logic            hold_capture;
    logic            push;
    logic            pop;
    logic [7:0]      push_data;
    logic            tx_next;
    logic [31:0]     status;
    logic [31:0]     rd_mux;
    logic [7:0]      cnt8;
    logic            unused_wdata;

    assign unused_wdata = ^bus.mem_wdata[31:8];

    // A valid hold byte is older than any new store, so it owns the FIFO push
    // slot and any store arriving while it is pending is dropped.
    always_comb begin
        wr_en        = bus.io_sel & (|bus.mem_wmask);
        data_wr      = wr_en & (bus.reg_addr == 2'd0) & bus.mem_wmask[0];
        ctrl_wr      = wr_en & (bus.reg_addr == 2'd2);
        rd_en        = bus.io_sel & bus.mem_rstrb;
        fifo_full    = (count == CNTW'(FIFO_DEPTH));
        fifo_empty   = (count == '0);
        push_wr      = data_wr & ~fifo_full & ~hold_valid;
        hold_xfer    = hold_valid & ~fifo_full;
        hold_capture = data_wr & fifo_full & ~hold_valid;
        push         = push_wr | hold_xfer;
        pop          = (state == S_IDLE) & ~fifo_empty;
        push_data    = hold_valid ? hold_data : bus.mem_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            hold_valid <= 1'b0;
            hold_data  <= 8'h00;
            overflow   <= 1'b0;
            irq_en     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CNTW'(1);
            end else if (pop && !push) begin
                count <= count - CNTW'(1);
            end

            if (hold_capture) begin
                hold_valid <= 1'b1;
                hold_data  <= bus.mem_wdata[7:0];
            end else if (hold_xfer) begin
                hold_valid <= 1'b0;
            end

            if (data_wr && hold_valid) begin
                overflow <= 1'b1;
            end else if (ctrl_wr && bus.mem_wdata[1]) begin
                overflow <= 1'b0;
            end

            if (ctrl_wr) begin
                irq_en <= bus.mem_wdata[0];
            end
        end
    end

    always_comb begin
        case (state)
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = shreg[bit_idx];
            default: tx_next = 1'b1;
        endcase
    end

    // tx is the registered image of the current state, so the line trails the
    // FSM by one cycle and never glitches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
            tx_q     <= 1'b1;
        end else begin
            tx_q <= tx_next;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shreg    <= fifo_mem[rd_ptr];
                        baud_cnt <= CW'(DIV - 1);
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= CW'(DIV - 1);
                        bit_idx  <= 3'd0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= CW'(DIV - 1);
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
                default: begin
                    if (baud_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        cnt8   = 8'(count);
        status = {16'h0000, cnt8, 3'b000, hold_valid, overflow,
                  fifo_empty, fifo_full, (state != S_IDLE)};
        case (bus.reg_addr)
            2'd1:    rd_mux = status;
            2'd2:    rd_mux = {30'b0, 1'b0, irq_en};
            default: rd_mux = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= 32'h0000_0000;
            irq_q   <= 1'b0;
        end else begin
            if (rd_en) begin
                rdata_q <= rd_mux;
            end
            irq_q <= irq_en & fifo_empty & ~hold_valid & (state == S_IDLE);
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_rbusy = 1'b0;
    assign bus.mem_wbusy = hold_valid;
    assign tx            = tx_q;
    assign irq           = irq_q;
endmodule

// File: tb/tb_io_uart_tx.sv
// tb/tb_io_uart_tx.sv - directed scoreboard bench for io_uart_tx at DIV=10
module tb_io_uart_tx;
    localparam int DIV = 10;

    logic clk;
    logic reset;
    logic tx;
    logic irq;
    int   cyc;
    int   n_checks;
    int   n_errors;
    logic [7:0] sb [$];

    io_uart_tx_if bus ();

    io_uart_tx #(
        .CLK_HZ    (1000000),
        .BAUD      (100000),
        .FIFO_DEPTH(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .tx   (tx),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.io_sel    = 1'b1;
        bus.reg_addr  = a;
        bus.mem_wdata = d;
        bus.mem_wmask = m;
        @(negedge clk);
        bus.io_sel    = 1'b0;
        bus.mem_wmask = 4'h0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.io_sel    = 1'b1;
        bus.reg_addr  = a;
        bus.mem_rstrb = 1'b1;
        @(negedge clk);
        bus.io_sel    = 1'b0;
        bus.mem_rstrb = 1'b0;
        d = bus.mem_rdata;
    endtask

    // Serial decoder: samples each bit mid-cell and scores whole frames only.
    initial begin
        logic [7:0] b;
        logic       stop_bit;
        logic       abort;
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && reset === 1'b1) begin
                abort = 1'b0;
                repeat (DIV / 2) @(negedge clk);
                if (reset !== 1'b1) abort = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = tx;
                    if (reset !== 1'b1) abort = 1'b1;
                end
                repeat (DIV) @(negedge clk);
                stop_bit = tx;
                if (reset !== 1'b1) abort = 1'b1;
                if (!abort) begin
                    if (sb.size() == 0) begin
                        check("unexpected_frame", {24'h0, b}, 32'hFFFF_FFFF);
                    end else begin
                        exp_b = sb.pop_front();
                        check("frame_byte", {24'h0, b}, {24'h0, exp_b});
                        check("frame_stop", {31'h0, stop_bit}, 32'h1);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] rd;
        int e;
        int e0;
        int t;
        int irq_bad;
        int tx_low;

        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b0;
        bus.io_sel    = 1'b0;
        bus.reg_addr  = 2'd0;
        bus.mem_wdata = 32'h0;
        bus.mem_wmask = 4'h0;
        bus.mem_rstrb = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_tx", {31'h0, tx}, 32'h1);
        check("rst_wbusy", {31'h0, bus.mem_wbusy}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_rdata", bus.mem_rdata, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        bus_read(2'd1, rd);
        check("idle_status", rd, 32'h0000_0004);
        check("rbusy", {31'h0, bus.mem_rbusy}, 32'h0);

        // Single byte, exact edge timing.
        sb.push_back(8'h55);
        bus_write(2'd0, 32'h55, 4'h1);
        e = cyc;
        @(negedge clk);
        check("tx_e1_high", {31'h0, tx}, 32'h1);
        @(negedge clk);
        check("tx_e2_start", {31'h0, tx}, 32'h0);
        repeat (89) @(negedge clk);
        check("tx_e91_bit7", {31'h0, tx}, 32'h0);
        @(negedge clk);
        check("tx_e92_stop", {31'h0, tx}, 32'h1);
        repeat (8) @(negedge clk);
        bus_read(2'd1, rd);
        check("busy_e101", rd, 32'h0000_0005);
        bus_read(2'd1, rd);
        check("busy_e102", rd, 32'h0000_0004);
        check("cyc_e102", cyc, e + 102);

        // Fill the FIFO while the first byte is popped, then overflow into hold.
        e0 = 0;
        for (int i = 0; i < 9; i++) begin
            sb.push_back(8'(i));
            bus_write(2'd0, 32'(i), 4'h1);
            if (i == 0) e0 = cyc;
        end
        bus_read(2'd1, rd);
        check("full_status", rd, 32'h0000_0803);
        check("full_wbusy", {31'h0, bus.mem_wbusy}, 32'h0);
        sb.push_back(8'h09);
        bus_write(2'd0, 32'h09, 4'h1);
        check("hold_wbusy_rise", {31'h0, bus.mem_wbusy}, 32'h1);
        t = 0;
        while (bus.mem_wbusy === 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("wbusy_fall_cycle", cyc, e0 + 103);

        // Second hold fill, then a store into a valid hold register is dropped.
        sb.push_back(8'h0A);
        bus_write(2'd0, 32'h0A, 4'h1);
        check("hold2_wbusy", {31'h0, bus.mem_wbusy}, 32'h1);
        bus_write(2'd0, 32'h0B, 4'h1);
        bus_read(2'd1, rd);
        check("ovf_status", rd, 32'h0000_081B);
        bus_write(2'd2, 32'h2, 4'h1);
        bus_read(2'd1, rd);
        check("ovf_cleared", rd, 32'h0000_0813);
        bus_read(2'd2, rd);
        check("ctrl_read", rd, 32'h0);
        bus_write(2'd3, 32'hFF, 4'hF);
        bus_read(2'd3, rd);
        check("reserved_read", rd, 32'h0);

        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", sb.size(), 32'h0);
        repeat (20) @(negedge clk);
        bus_read(2'd1, rd);
        check("drain_status", rd, 32'h0000_0004);

        // Transmit-complete interrupt.
        sb.push_back(8'hA5);
        bus_write(2'd0, 32'hA5, 4'h1);
        e = cyc;
        bus_write(2'd2, 32'h1, 4'h1);
        irq_bad = 0;
        while (cyc < e + 102) begin
            if (irq !== 1'b0) irq_bad++;
            @(negedge clk);
        end
        check("irq_low_in_frame", irq_bad, 32'h0);
        check("irq_rise", {31'h0, irq}, 32'h1);
        bus_write(2'd2, 32'h0, 4'h1);
        @(negedge clk);
        check("irq_clear", {31'h0, irq}, 32'h0);
        repeat (10) @(negedge clk);

        // Reset in the middle of data bit 3.
        sb.push_back(8'hC3);
        bus_write(2'd0, 32'hC3, 4'h1);
        e = cyc;
        repeat (46) @(negedge clk);
        #1 reset = 1'b0;
        sb.delete();
        #1;
        check("midrst_tx", {31'h0, tx}, 32'h1);
        check("midrst_wbusy", {31'h0, bus.mem_wbusy}, 32'h0);
        check("midrst_rdata", bus.mem_rdata, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        tx_low = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low++;
        end
        check("postrst_no_frame", tx_low, 32'h0);
        bus_read(2'd1, rd);
        check("postrst_status", rd, 32'h0000_0004);
        check("postrst_irq", {31'h0, irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
